regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter_pkg.sv | 17 +
 rtl/regfile_write_arbiter_rr.sv | 14 +
 rtl/regfile_write_arbiter.sv | 89 ++++++++
 tb/tb_regfile_write_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Covers the FSM states, the default widths and the encoding of the last-grant flag.
package regfile_write_arbiter_pkg;

    localparam int RN_DEF = 5;
    localparam int N_DEF  = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Encoding of the last_grant flag: which requester won the last transfer.
    localparam logic GNT_REQ0 = 1'b0;
    localparam logic GNT_REQ1 = 1'b1;

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Two-way round-robin selector producing a one-hot grant.
// Under contention it picks the requester that did not win last.
module rr_arbiter2
    import regfile_write_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    assign grant[0] = valid[0] & (~valid[1] | (last_grant == GNT_REQ1));
    assign grant[1] = valid[1] & (~valid[0] | (last_grant == GNT_REQ0));

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: clears registers 1..2^RN-1 after reset,
// then arbitrates two write requesters round-robin with a registered output stage.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int RN = RN_DEF,
    parameter int N  = N_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [RN-1:0] req0_addr,
    input  logic [N-1:0]  req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [RN-1:0] req1_addr,
    input  logic [N-1:0]  req1_data,
    output logic          req1_ready,
    output logic          regWrite,
    output logic [RN-1:0] A3,
    output logic [N-1:0]  WD,
    output logic          init_done
);

    state_t        state, state_nxt;
    logic [RN-1:0] idx;
    logic          last_grant;
    logic [1:0]    grant;
    logic [1:0]    ready;
    logic          xfer;
    logic          sweep_last;
    logic [RN-1:0] sel_addr;
    logic [N-1:0]  sel_data;

    rr_arbiter2 u_rr (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign sweep_last = (idx == {RN{1'b1}});

    always_comb begin
        state_nxt = state;
        ready     = 2'b00;
        case (state)
            INIT: if (sweep_last) state_nxt = RUN;
            RUN:  ready = rst ? 2'b00 : grant;
            default: state_nxt = INIT;
        endcase
    end

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign xfer       = |ready;
    assign sel_addr   = ready[1] ? req1_addr : req0_addr;
    assign sel_data   = ready[1] ? req1_data : req0_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= RN'(1);
            last_grant <= GNT_REQ1;
            regWrite   <= 1'b0;
            A3         <= '0;
            WD         <= '0;
            init_done  <= 1'b0;
        end else if (state == INIT) begin
            regWrite <= 1'b1;
            A3       <= idx;
            WD       <= '0;
            idx      <= idx + RN'(1);
            if (sweep_last) init_done <= 1'b1;
        end else begin
            // Writes to register 0 still consume a grant but never reach the file.
            regWrite <= xfer && (sel_addr != '0);
            if (xfer) last_grant <= ready[1] ? GNT_REQ1 : GNT_REQ0;
            if (xfer && (sel_addr != '0)) begin
                A3 <= sel_addr;
                WD <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared every
// cycle against a behavioural model of the sweep and round-robin rules.
module tb_regfile_write_arbiter;

    localparam int RN   = 5;
    localparam int N    = 32;
    localparam int NREG = 1 << RN;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [RN-1:0] req0_addr = '0, req1_addr = '0;
    logic [N-1:0]  req0_data = '0, req1_data = '0;
    logic          req0_ready, req1_ready, regWrite, init_done;
    logic [RN-1:0] A3;
    logic [N-1:0]  WD;

    regfile_write_arbiter #(.RN(RN), .N(N)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .regWrite(regWrite), .A3(A3), .WD(WD), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit            m_run;
    int            m_sweep;
    int            m_last;
    int            m_w;
    logic          m_we;
    logic [RN-1:0] m_a3;
    logic [N-1:0]  m_wd;
    logic          m_done;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_sweep = 1; m_last = 1; m_w = -1;
        m_we = 1'b0; m_a3 = '0; m_wd = '0; m_done = 1'b0;
    endtask

    function automatic int winner();
        if (!m_run) return -1;
        if (req0_valid && req1_valid) return (m_last == 0) ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    // One clock cycle: compare at negedge, advance model at posedge, return at posedge+1.
    task automatic step();
        logic [RN-1:0] a;
        logic [N-1:0]  d;
        @(negedge clk);
        m_w = winner();
        chk("req0_ready", req0_ready, (m_w == 0));
        chk("req1_ready", req1_ready, (m_w == 1));
        chk("regWrite", regWrite, m_we);
        chk("A3", A3, m_a3);
        chk("WD", WD, m_wd);
        chk("init_done", init_done, m_done);
        @(posedge clk);
        if (!m_run) begin
            m_we = 1'b1; m_a3 = RN'(m_sweep); m_wd = '0;
            if (m_sweep == NREG - 1) begin m_run = 1; m_done = 1'b1; end
            m_sweep++;
        end else if (m_w >= 0) begin
            m_last = m_w;
            a = (m_w == 1) ? req1_addr : req0_addr;
            d = (m_w == 1) ? req1_data : req0_data;
            if (a != '0) begin m_we = 1'b1; m_a3 = a; m_wd = d; end
            else m_we = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_regWrite", regWrite, 0);
        chk("rst_A3", A3, 0);
        chk("rst_WD", WD, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [RN-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return RN'($urandom_range(0, 2));
        return RN'($urandom_range(0, NREG - 1));
    endfunction

    initial begin
        model_reset();
        // Requester 0 waits through the whole clear sweep.
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'hA5A5_0009;
        #2;
        do_reset();
        for (int i = 0; i < NREG - 1; i++) begin
            step();
            if (i == 0) begin
                chk("sweep_first_A3", A3, 1);
                chk("sweep_first_WD", WD, 0);
            end
        end
        chk("sweep_end_A3", A3, 31);
        chk("sweep_end_done", init_done, 1);
        chk("sweep_end_we", regWrite, 1);
        chk("run_first_ready0", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        chk("held_req_we", regWrite, 1);
        chk("held_req_A3", A3, 9);
        chk("held_req_WD", WD, 32'hA5A5_0009);

        // Single write
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        #1 chk("single_ready0", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        chk("single_we", regWrite, 1);
        chk("single_A3", A3, 5);
        chk("single_WD", WD, 32'hDEADBEEF);
        step();
        chk("single_idle_we", regWrite, 0);
        chk("single_idle_A3", A3, 5);

        // Write to register 0 is accepted but suppressed
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h0000FFFF;
        #1 chk("zero_ready1", req1_ready, 1);
        step();
        req1_valid = 1'b0;
        chk("zero_we", regWrite, 0);

        // Contention on one address: strict alternation starting with requester 0
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("alt_ready0", req0_ready, (k % 2 == 0));
            chk("alt_ready1", req1_ready, (k % 2 == 1));
            step();
            chk("alt_we", regWrite, 1);
            chk("alt_A3", A3, 3);
            chk("alt_WD", WD, (k % 2 == 0) ? 32'h11 : 32'h22);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Reset pulsed the cycle after a transfer
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
        step();
        req0_valid = 1'b0;
        chk("pre_rst_A3", A3, 7);
        do_reset();
        step();
        chk("post_rst_we", regWrite, 1);
        chk("post_rst_A3", A3, 1);
        chk("post_rst_WD", WD, 0);
        chk("post_rst_done", init_done, 0);

        // Randomized traffic obeying the hold-while-not-ready protocol
        for (int i = 0; i < 3000; i++) begin
            if (!(req0_valid && m_w != 0)) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_addr  = rnd_addr();
                req0_data  = $urandom;
            end
            if (!(req1_valid && m_w != 1)) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_addr  = rnd_addr();
                req1_data  = $urandom;
            end
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
                m_w = -1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
